// File: rtl/life_next_gen_writer.sv
// rtl/life_next_gen_writer.sv - Conway next-generation row packer with row write port
//
// Purpose: applies the Conway rules to a stream of 3x3 window sums (centre
// included), packs the resulting cells into ROW_W-bit row words and presents
// each completed row with its row address on a valid/ready port. Tracks the
// population of the generation being produced and flags illegal window sums.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              1-cycle pulse: flush and begin a new generation
//   in_valid/in_ready  beat handshake carrying life (0..9) and cell_cur
//   out_valid/out_ready row handshake carrying out_row and out_addr
//   gen_done           1-cycle pulse on the handshake of row ROWS-1
//   pop_count          live cells produced so far this generation
//   range_err          sticky: a beat arrived with life > 9
module life_next_gen_writer #(
    parameter int ROW_W  = 16,
    parameter int ROWS   = 16,
    parameter int ADDR_W = 4,
    parameter int POP_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        life,
    input  logic              cell_cur,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  out_row,
    output logic [ADDR_W-1:0] out_addr,
    output logic              gen_done,
    output logic [POP_W-1:0]  pop_count,
    output logic              range_err
);

    localparam int COL_W = (ROW_W > 1) ? $clog2(ROW_W) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] row;
    logic [ROW_W-1:0]  shreg;
    logic [ROW_W-1:0]  row_word;
    logic              accept;
    logic              next_cell;
    logic              last_col;
    logic              last_row;
    logic              row_done;
    logic              out_fire;

    assign last_col  = (col == COL_W'(ROW_W - 1));
    assign last_row  = (row == ADDR_W'(ROWS - 1));
    assign out_fire  = out_valid & out_ready;

    // Only the row-closing beat has to wait for the holding register; earlier
    // beats of the next row land in the shift register while a row is pending.
    assign in_ready  = ~rst & (state_q == RUN) & ~start
                     & ~(last_col & out_valid & ~out_ready);
    assign accept    = in_valid & in_ready;

    // Sums above 9 cannot equal 3 or 4, so an illegal beat yields a dead cell.
    assign next_cell = (life == 4'd3) | ((life == 4'd4) & cell_cur);
    assign row_done  = accept & last_col;
    assign gen_done  = (state_q == DRAIN) & out_fire;

    // Completed row including the beat being accepted this cycle.
    always_comb begin
        row_word      = shreg;
        row_word[col] = next_cell;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (row_done && last_row) state_d = DRAIN;
                DRAIN:   if (out_fire) state_d = IDLE;
                IDLE:    state_d = IDLE;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            shreg     <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_addr  <= '0;
            pop_count <= '0;
            range_err <= 1'b0;
        end else if (start) begin
            // Flush: any pending row and partial row are discarded.
            col       <= '0;
            row       <= '0;
            shreg     <= '0;
            out_valid <= 1'b0;
            pop_count <= '0;
            range_err <= 1'b0;
        end else begin
            if (accept) begin
                pop_count <= pop_count + POP_W'(next_cell);
                if (life > 4'd9) begin
                    range_err <= 1'b1;
                end
                if (last_col) begin
                    col   <= '0;
                    row   <= row + ADDR_W'(1);
                    shreg <= '0;
                end else begin
                    col   <= col + COL_W'(1);
                    shreg <= row_word;
                end
            end

            // A new row completing on the handshake cycle keeps out_valid high.
            if (row_done) begin
                out_valid <= 1'b1;
                out_row   <= row_word;
                out_addr  <= row;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_life_next_gen_writer.sv
// tb/tb_life_next_gen_writer.sv - scoreboard bench for life_next_gen_writer
module tb_life_next_gen_writer;

    localparam int ROW_W  = 16;
    localparam int ROWS   = 16;
    localparam int ADDR_W = 4;
    localparam int POP_W  = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        life = 4'd0;
    logic              cell_cur = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ROW_W-1:0]  out_row;
    logic [ADDR_W-1:0] out_addr;
    logic              gen_done;
    logic [POP_W-1:0]  pop_count;
    logic              range_err;

    life_next_gen_writer #(
        .ROW_W(ROW_W), .ROWS(ROWS), .ADDR_W(ADDR_W), .POP_W(POP_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .life(life), .cell_cur(cell_cur),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_addr(out_addr),
        .gen_done(gen_done), .pop_count(pop_count), .range_err(range_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: rows are assembled cell by cell from the rules.
    logic [ADDR_W+ROW_W-1:0] exp_q[$];
    int               m_col = 0;
    int               m_row = 0;
    int               m_pop = 0;
    logic             m_err = 1'b0;
    logic [ROW_W-1:0] m_word = '0;

    bit hold_ready = 1'b0;
    int ready_pct  = 100;
    int gen_cnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_beat(input logic [3:0] l, input logic c);
        logic alive;
        alive = (l == 4'd3) || (l == 4'd4 && c);
        if (l > 4'd9) m_err = 1'b1;
        m_word[m_col] = alive;
        m_pop += int'(alive);
        m_col++;
        if (m_col == ROW_W) begin
            exp_q.push_back({ADDR_W'(m_row), m_word});
            m_row++;
            m_col  = 0;
            m_word = '0;
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        m_col = 0; m_row = 0; m_pop = 0; m_err = 1'b0; m_word = '0;
        gen_cnt = 0;
    endtask

    // Present one beat until accepted (bounded); model updated on acceptance.
    task automatic beat(input logic [3:0] l, input logic c, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        life = l; cell_cur = c; in_valid = 1'b1;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (in_ready) begin
                model_beat(l, c);
                ok = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL beat_timeout: in_ready stayed low, row %0d col %0d", m_row, m_col);
        end
    endtask

    task automatic mode_beat(input int mode, output bit ok);
        logic [3:0] l;
        logic       c;
        case (mode)
            0: begin l = 4'd3; c = 1'b0; end
            1: begin l = 4'd4; c = (m_col % 2 == 0); end
            2: begin l = 4'd2; c = 1'b1; end
            default: begin
                l = ($urandom_range(19) == 0) ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9));
                c = 1'($urandom_range(1));
            end
        endcase
        beat(l, c, ok);
    endtask

    task automatic run_gen(input int mode);
        bit ok;
        while (m_row < ROWS) begin
            mode_beat(mode, ok);
            if (!ok) return;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic end_gen();
        wait_drain();
        check("pop_count", pop_count, m_pop);
        check("range_err", range_err, m_err);
        check("gen_done_pulses", gen_cnt, 1);
        in_valid = 1'b1; life = 4'd3;
        @(negedge clk);
        check("refuse_after_gen", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        hold_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; in_valid = 1'b1; life = 4'd3; cell_cur = 1'b0;
        @(negedge clk);
        check("in_ready_on_start", in_ready, 0);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        model_flush();
        @(negedge clk);
        check("start_out_valid", out_valid, 0);
        check("start_pop_count", pop_count, 0);
        check("start_range_err", range_err, 0);
        @(posedge clk); #1;
        hold_ready = 1'b0;
    endtask

    // Downstream ready driver.
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = hold_ready ? 1'b0 : ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: a row transfers on the edge following a valid&ready sample.
    always @(negedge clk) begin
        if (!rst) begin
            if (gen_done) gen_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_row: got addr %0d row %0h expected none", out_addr, out_row);
                end else begin
                    logic [ADDR_W+ROW_W-1:0] e;
                    e = exp_q.pop_front();
                    check("out_row", out_row, e[ROW_W-1:0]);
                    check("out_addr", out_addr, e[ROW_W +: ADDR_W]);
                    check("gen_done", gen_done, (e[ROW_W +: ADDR_W] == ADDR_W'(ROWS - 1)));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_row", out_row, 0);
        check("reset_out_addr", out_addr, 0);
        check("reset_gen_done", gen_done, 0);
        check("reset_pop_count", pop_count, 0);
        check("reset_range_err", range_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_flush();

        // All cells born: every row all ones, full population.
        ready_pct = 100;
        run_gen(0);
        end_gen();
        check("pop_all_ones", pop_count, ROW_W * ROWS);
        do_start();

        // Alternating survivors, then all dying.
        ready_pct = 70;
        run_gen(1);
        end_gen();
        do_start();
        run_gen(2);
        end_gen();
        do_start();

        // Backpressure: row-closing beat stalls while row 0 is held.
        ready_pct = 100;
        hold_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < ROW_W; k++) beat(4'd3, 1'b0, ok);
        for (int k = 0; k < ROW_W - 1; k++) beat(4'd4, 1'(k % 2), ok);
        life = 4'd4; cell_cur = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_addr", out_addr, 0);
            check("stall_out_row", out_row, 16'hFFFF);
            @(posedge clk); #1;
        end
        hold_ready = 1'b0;
        beat(4'd4, 1'b0, ok);
        ready_pct = 80;
        run_gen(3);
        end_gen();
        do_start();

        // Illegal window sum.
        ready_pct = 90;
        beat(4'd12, 1'b1, ok);
        @(negedge clk);
        check("range_err_set", range_err, 1);
        @(posedge clk); #1;
        run_gen(3);
        end_gen();
        check("range_err_held", range_err, 1);
        do_start();

        // start with a row pending mid-generation.
        ready_pct = 60;
        while (m_row < 2) begin
            mode_beat(3, ok);
            if (!ok) break;
        end
        wait_drain();
        hold_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < ROW_W + 7; k++) mode_beat(3, ok);
        @(negedge clk);
        check("pending_before_start", out_valid, 1);
        @(posedge clk); #1;
        do_start();
        ready_pct = 100;
        run_gen(3);
        end_gen();
        do_start();

        // Asynchronous reset mid-row with a row pending.
        hold_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < ROW_W + 5; k++) beat(4'd3, 1'b0, ok);
        #1;
        rst = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_out_row", out_row, 0);
        check("async_out_addr", out_addr, 0);
        check("async_pop_count", pop_count, 0);
        check("async_in_ready", in_ready, 0);
        check("async_range_err", range_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_flush();
        hold_ready = 1'b0;

        // Random generations.
        for (int g = 0; g < 3; g++) begin
            ready_pct = int'($urandom_range(90, 40));
            run_gen(3);
            end_gen();
            do_start();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
